bcd_mod_counter: RTL and testbench

//  Parametrised two-digit BCD modulo counter; next-generation digit counter for the clock chain (sec/min/hour, timer).

---
 rtl/bcd_mod_counter.sv | 141 ++++++++++++++
 tb/tb_bcd_mod_counter.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/bcd_mod_counter.sv
// -----------------------------------------------------------------------------
// bcd_mod_counter
//   Two-digit BCD modulo counter for the clock chain (sec/min/hour, timer).
//   Counts up or down between MINV and MAXV on a cascade tick. It also supports
//   manual +1/-1 adjust and a parallel load, and emits carry/borrow so the next
//   stage can be cascaded from it.
//
// Parameters
//   MAXV  upper bound (decimal), MAXV <= 10*(2**QH_W)-1
//   MINV  lower bound (decimal), MINV < MAXV
//   QH_W  width of the tens digit
//
// Ports
//   clk_i    in   1     clock
//   rst_i    in   1     synchronous reset, active-high; loads MINV digits
//   en_i     in   1     cascade tick: one step in direction dir_i
//   dir_i    in   1     0 = up, 1 = down (qualifies en_i only)
//   inc_i    in   1     manual +1 adjust
//   dec_i    in   1     manual -1 adjust
//   ld_i     in   1     parallel load of dh_i:dl_i
//   dh_i     in   QH_W  load value, tens digit
//   dl_i     in   4     load value, ones digit
//   qh_o     out  QH_W  tens digit
//   ql_o     out  4     ones digit
//   ca_o     out  1     carry (combinational), en & up & Q==MAXV & ~ld
//   br_o     out  1     borrow (combinational), en & down & Q==MINV & ~ld
//   lderr_o  out  1     one-cycle pulse: previous load value was rejected
// -----------------------------------------------------------------------------
module bcd_mod_counter #(
  parameter int MAXV = 59,
  parameter int MINV = 0,
  parameter int QH_W = 3
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            en_i,
  input  logic            dir_i,
  input  logic            inc_i,
  input  logic            dec_i,
  input  logic            ld_i,
  input  logic [QH_W-1:0] dh_i,
  input  logic [3:0]      dl_i,
  output logic [QH_W-1:0] qh_o,
  output logic [3:0]      ql_o,
  output logic            ca_o,
  output logic            br_o,
  output logic            lderr_o
);

  // 10*(2**QH_W - 1) + 15 always fits in QH_W+4 bits.
  localparam int VW = QH_W + 4;

  localparam logic [QH_W-1:0] MIN_H = QH_W'(MINV / 10);
  localparam logic [3:0]      MIN_L = 4'(MINV % 10);
  localparam logic [QH_W-1:0] MAX_H = QH_W'(MAXV / 10);
  localparam logic [3:0]      MAX_L = 4'(MAXV % 10);
  localparam logic [VW-1:0]   MIN_V = VW'(MINV);
  localparam logic [VW-1:0]   MAX_V = VW'(MAXV);

  function automatic logic [VW-1:0] bcd_value(input logic [QH_W-1:0] h,
                                              input logic [3:0]      l);
    return VW'(h) * VW'(10) + VW'(l);
  endfunction

  logic [QH_W-1:0] qh_q, qh_d;
  logic [3:0]      ql_q, ql_d;
  logic            lderr_q, lderr_d;

  logic [VW-1:0] q_val;
  logic [VW-1:0] ld_val;
  logic          ld_ok;
  logic          at_max, at_min;
  logic          up_req, down_req;

  assign q_val  = bcd_value(qh_q, ql_q);
  assign ld_val = bcd_value(dh_i, dl_i);
  assign ld_ok  = (dl_i <= 4'd9) && (ld_val >= MIN_V) && (ld_val <= MAX_V);
  assign at_max = (q_val == MAX_V);
  assign at_min = (q_val == MIN_V);

  // Cascade tick and manual adjust merge, so EN-up together with INC steps once.
  assign up_req   = (en_i & ~dir_i) | inc_i;
  assign down_req = (en_i &  dir_i) | dec_i;

  // Carry/borrow come only from the cascade tick, so a manual adjust never
  // ripples into the next stage. They are not masked by an up/down cancel.
  assign ca_o = en_i & ~dir_i & at_max & ~ld_i;
  assign br_o = en_i &  dir_i & at_min & ~ld_i;

  always_comb begin
    qh_d    = qh_q;
    ql_d    = ql_q;
    lderr_d = 1'b0;
    if (ld_i) begin
      if (ld_ok) begin
        qh_d = dh_i;
        ql_d = dl_i;
      end else begin
        lderr_d = 1'b1;
      end
    end else if (up_req && !down_req) begin
      // Full-value compare, so bounds whose ones digit is not 9 (e.g. 23) wrap.
      if (at_max) begin
        qh_d = MIN_H;
        ql_d = MIN_L;
      end else if (ql_q == 4'd9) begin
        qh_d = qh_q + 1'b1;
        ql_d = 4'd0;
      end else begin
        ql_d = ql_q + 4'd1;
      end
    end else if (down_req && !up_req) begin
      if (at_min) begin
        qh_d = MAX_H;
        ql_d = MAX_L;
      end else if (ql_q == 4'd0) begin
        qh_d = qh_q - 1'b1;
        ql_d = 4'd9;
      end else begin
        ql_d = ql_q - 4'd1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      qh_q    <= MIN_H;
      ql_q    <= MIN_L;
      lderr_q <= 1'b0;
    end else begin
      qh_q    <= qh_d;
      ql_q    <= ql_d;
      lderr_q <= lderr_d;
    end
  end

  assign qh_o    = qh_q;
  assign ql_o    = ql_q;
  assign lderr_o = lderr_q;

endmodule

// File: tb/tb_bcd_mod_counter.sv
module tb_bcd_mod_counter;

  logic       clk = 1'b0;
  logic       rst, en, dir, inc, dec, ld;
  logic [2:0] dh;
  logic [3:0] dl;

  // A: 0..59, B: 0..23, C: 1..31 -- all driven from the same stimulus.
  logic [2:0] a_qh, b_qh, c_qh;
  logic [3:0] a_ql, b_ql, c_ql;
  logic       a_ca, b_ca, c_ca, a_br, b_br, c_br, a_le, b_le, c_le;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  bcd_mod_counter #(.MAXV(59), .MINV(0), .QH_W(3)) u_a (
    .clk_i(clk), .rst_i(rst), .en_i(en), .dir_i(dir), .inc_i(inc), .dec_i(dec),
    .ld_i(ld), .dh_i(dh), .dl_i(dl), .qh_o(a_qh), .ql_o(a_ql),
    .ca_o(a_ca), .br_o(a_br), .lderr_o(a_le));

  bcd_mod_counter #(.MAXV(23), .MINV(0), .QH_W(3)) u_b (
    .clk_i(clk), .rst_i(rst), .en_i(en), .dir_i(dir), .inc_i(inc), .dec_i(dec),
    .ld_i(ld), .dh_i(dh), .dl_i(dl), .qh_o(b_qh), .ql_o(b_ql),
    .ca_o(b_ca), .br_o(b_br), .lderr_o(b_le));

  bcd_mod_counter #(.MAXV(31), .MINV(1), .QH_W(3)) u_c (
    .clk_i(clk), .rst_i(rst), .en_i(en), .dir_i(dir), .inc_i(inc), .dec_i(dec),
    .ld_i(ld), .dh_i(dh), .dl_i(dl), .qh_o(c_qh), .ql_o(c_ql),
    .ca_o(c_ca), .br_o(c_br), .lderr_o(c_le));

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed 'h%0h expected 'h%0h", tag, obs, exp);
  endtask

  // Counter values compared as packed BCD (e.g. 'h59).
  function automatic int qa(); return int'({1'b0, a_qh, a_ql}); endfunction
  function automatic int qb(); return int'({1'b0, b_qh, b_ql}); endfunction
  function automatic int qc(); return int'({1'b0, c_qh, c_ql}); endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rst = 0; en = 0; dir = 0; inc = 0; dec = 0; ld = 0; dh = 0; dl = 0;
  endtask

  task automatic load(input logic [2:0] h, input logic [3:0] l);
    idle();
    ld = 1; dh = h; dl = l;
    tick();
    ld = 0;
  endtask

  initial begin
    idle();
    rst = 1;
    tick();
    chk("rst_a_q", qa(), 'h00);
    chk("rst_a_lderr", int'(a_le), 0);
    chk("rst_b_q", qb(), 'h00);
    chk("rst_c_q", qc(), 'h01);

    // Reset mid-count
    load(3, 7);
    chk("ld37_a_q", qa(), 'h37);
    rst = 1;
    tick();
    chk("rst37_a_q", qa(), 'h00);

    // Up count with carry, 0..59
    load(5, 8);
    en = 1; dir = 0;
    #1 chk("a_ca_at58", int'(a_ca), 0);
    tick();
    chk("a_q_59", qa(), 'h59);
    chk("a_ca_at59", int'(a_ca), 1);
    tick();
    chk("a_q_wrap00", qa(), 'h00);
    chk("a_ca_after", int'(a_ca), 0);

    // Down count with borrow, 1..31
    load(0, 2);
    en = 1; dir = 1;
    #1 chk("c_br_at02", int'(c_br), 0);
    tick();
    chk("c_q_01", qc(), 'h01);
    chk("c_br_at01", int'(c_br), 1);
    tick();
    chk("c_q_wrap31", qc(), 'h31);
    chk("c_br_after", int'(c_br), 0);

    // Manual DEC at MINV wraps without borrow
    load(0, 1);
    dec = 1;
    #1 chk("c_br_dec", int'(c_br), 0);
    tick();
    chk("c_q_dec_wrap", qc(), 'h31);

    // 0..23 wrap at a bound whose ones digit is not 9
    load(2, 2);
    en = 1; dir = 0;
    #1 chk("b_ca_at22", int'(b_ca), 0);
    tick();
    chk("b_q_23", qb(), 'h23);
    chk("b_ca_at23", int'(b_ca), 1);
    tick();
    chk("b_q_wrap00", qb(), 'h00);
    chk("b_ca_after", int'(b_ca), 0);

    // Manual INC at MAXV: wrap, no carry
    load(5, 9);
    inc = 1;
    #1 chk("a_ca_inc59", int'(a_ca), 0);
    tick();
    chk("a_q_inc_wrap", qa(), 'h00);

    // EN-up with INC steps once; INC with DEC holds
    load(1, 0);
    en = 1; dir = 0; inc = 1;
    tick();
    chk("a_q_single_step", qa(), 'h11);
    load(1, 0);
    inc = 1; dec = 1;
    tick();
    chk("a_q_cancel", qa(), 'h10);

    // Up/down cancel at MAXV: carry still asserted, value holds
    load(5, 9);
    en = 1; dir = 0; dec = 1;
    #1 chk("a_ca_cancel", int'(a_ca), 1);
    tick();
    chk("a_q_cancel59", qa(), 'h59);

    // Loads: accept, out of range, illegal digit
    load(4, 5);
    chk("a_ld45_q", qa(), 'h45);
    chk("a_ld45_lderr", int'(a_le), 0);
    load(6, 0);
    chk("a_ld60_q", qa(), 'h45);
    chk("a_ld60_lderr", int'(a_le), 1);
    tick();
    chk("a_lderr_pulse", int'(a_le), 0);
    load(0, 10);
    chk("a_ld0A_q", qa(), 'h45);
    chk("a_ld0A_lderr", int'(a_le), 1);
    tick();

    // Load wins over EN at MAXV and suppresses carry
    load(5, 9);
    ld = 1; dh = 1; dl = 2; en = 1; dir = 0;
    #1 chk("a_ca_ld", int'(a_ca), 0);
    tick();
    chk("a_q_ld_wins", qa(), 'h12);
    idle();
    tick();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1);
  end

endmodule
